// File: rtl/adder_serial_acc.sv
// adder_serial_acc: multi-cycle ripple-carry adder with an accumulator.
// Operands are accepted through a valid/ready handshake, added CHUNK bits
// per cycle from the LSB slice upward, and the result (sum, carry, signed
// overflow) is offered through a second valid/ready handshake. In
// accumulate mode the last consumed result replaces operand A.
// Optional feature macro: ADDER_SUB_EN adds the `sub` port (A - B).

module adder_serial_acc #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_mode,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("adder_serial_acc: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a;       // latched operand A (a or acc)
    logic [WIDTH-1:0] op_b;       // latched operand B' (after optional inversion)
    logic [WIDTH-1:0] part;       // partial result, filled slice by slice
    logic [WIDTH-1:0] acc;        // last consumed result
    logic [IDX_W-1:0] idx;        // slice currently being added
    logic             carry;      // ripple carry between slices

    logic             accept;
    logic             last_step;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] part_nxt;
    logic [WIDTH-1:0] b_eff;
    logic             carry_init;

    assign accept = in_valid & in_ready;

    // Operand B as it enters the adder, and the carry the first slice sees.
`ifdef ADDER_SUB_EN
    assign b_eff      = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_eff      = b;
    assign carry_init = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one pass through RUN per operation, held in DONE
    // until the consumer takes the result.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (accept)               state_nxt = RUN;
            RUN:     if (last_step)            state_nxt = DONE;
            DONE:    if (out_valid & out_ready) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One CHUNK-bit slice of the ripple add, merged into the partial result.
    always_comb begin
        slice_a   = op_a[int'(idx)*CHUNK +: CHUNK];
        slice_b   = op_b[int'(idx)*CHUNK +: CHUNK];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
        part_nxt  = part;
        part_nxt[int'(idx)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        last_step = (idx == LAST_IDX);
    end

    // Datapath: latch operands on acceptance, ripple through the slices,
    // publish the result on the last slice and update acc on consumption.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            part  <= '0;
            acc   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= acc_mode ? acc : a;
                        op_b  <= b_eff;
                        carry <= carry_init;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    part  <= part_nxt;
                    carry <= slice_sum[CHUNK];
                    idx   <= idx + IDX_W'(1);
                    if (last_step) begin
                        sum  <= part_nxt;
                        cout <= slice_sum[CHUNK];
                        ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                                (part_nxt[WIDTH-1] != op_a[WIDTH-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_serial_acc.sv
// Self-checking bench for adder_serial_acc (WIDTH=8, CHUNK=2).
// A cycle-level behavioural model computes results with whole-word
// arithmetic; a compare process checks every output on every negedge, and
// directed vectors pin the model with hand-computed literals.
// Define ADDER_SUB_EN to also exercise subtraction.

module tb_adder_serial_acc;

    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int STEPS = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_mode;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    adder_serial_acc #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .acc_mode  (acc_mode),
`ifdef ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy counts the cycles of addition still to go; the result is
    // computed in one go at acceptance and published when busy reaches 0.
    bit               model_live = 1'b0;
    int               m_busy     = 0;
    bit               m_out_valid;
    logic [WIDTH-1:0] m_sum, m_acc, m_pend_sum;
    logic             m_cout, m_ovf, m_pend_cout, m_pend_ovf;

    always @(posedge clk) begin
        logic [WIDTH-1:0] opa, opb;
        logic             cin;
        logic [WIDTH:0]   full;
        model_live = 1'b1;
        if (rst) begin
            m_busy = 0; m_out_valid = 1'b0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_acc = '0;
        end else if (m_out_valid) begin
            if (out_ready) begin
                m_acc       = m_sum;
                m_out_valid = 1'b0;
            end
        end else if (m_busy != 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_sum = m_pend_sum; m_cout = m_pend_cout; m_ovf = m_pend_ovf;
                m_out_valid = 1'b1;
            end
        end else if (in_valid) begin
            opa = acc_mode ? m_acc : a;
`ifdef ADDER_SUB_EN
            cin = sub;
            opb = sub ? ~b : b;
`else
            cin = 1'b0;
            opb = b;
`endif
            full        = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
            m_pend_sum  = full[WIDTH-1:0];
            m_pend_cout = full[WIDTH];
            m_pend_ovf  = (opa[WIDTH-1] == opb[WIDTH-1]) && (full[WIDTH-1] != opa[WIDTH-1]);
            m_busy      = STEPS;
        end
    end

    // Compare every output against the model on every cycle.
    always @(negedge clk) begin
        if (model_live) begin
            check("cmp in_ready",  32'(in_ready),  32'(!m_out_valid && m_busy == 0));
            check("cmp out_valid", 32'(out_valid), 32'(m_out_valid));
            check("cmp sum",       32'(sum),       32'(m_sum));
            check("cmp cout",      32'(cout),      32'(m_cout));
            check("cmp ovf",       32'(ovf),       32'(m_ovf));
        end
    end

    // ---------------- directed stimulus ----------------
    // Runs one operation from IDLE; returns the result seen in DONE.
    // Inputs are scrambled after acceptance and in_valid is pulsed while
    // busy; hold keeps out_ready low that many cycles in DONE.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic am, input logic sb, input int hold,
                         output logic [WIDTH-1:0] rs, output logic rc, output logic ro);
        int n;
        a = av; b = bv; acc_mode = am; sub = sb; in_valid = 1'b1;
        @(negedge clk);
        a = ~av; b = ~bv; acc_mode = ~am; sub = ~sb; in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
            in_valid = n[0];
        end
        check("latency", 32'(n), 32'(STEPS));
        rs = sum; rc = cout; ro = ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold in_ready",  32'(in_ready),  32'd0);
            check("hold sum",       32'(sum),       32'(rs));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready after consume", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] rs;
        logic             rc, ro;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; acc_mode = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum",       32'(sum),       32'd0);
        check("reset cout",      32'(cout),      32'd0);
        check("reset ovf",       32'(ovf),       32'd0);

        // Basic add: 0x5A + 0x3C = 0x96, signed overflow.
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, rs, rc, ro);
        check("basic sum", 32'(rs), 32'h96);
        check("basic cout", 32'(rc), 32'd0);
        check("basic ovf", 32'(ro), 32'd1);

        // Accumulate: acc(0x96) + 0x10 = 0xA6, a ignored.
        do_op(8'h77, 8'h10, 1'b1, 1'b0, 0, rs, rc, ro);
        check("acc sum", 32'(rs), 32'hA6);
        check("acc cout", 32'(rc), 32'd0);
        check("acc ovf", 32'(ro), 32'd0);

        // Wrap-around with 3 cycles of backpressure.
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 3, rs, rc, ro);
        check("wrap sum", 32'(rs), 32'h00);
        check("wrap cout", 32'(rc), 32'd1);
        check("wrap ovf", 32'(ro), 32'd0);

        // Signed boundaries.
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1, rs, rc, ro);
        check("7f+1 sum", 32'(rs), 32'h80);
        check("7f+1 ovf", 32'(ro), 32'd1);
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 0, rs, rc, ro);
        check("80+80 sum", 32'(rs), 32'h00);
        check("80+80 cout", 32'(rc), 32'd1);
        check("80+80 ovf", 32'(ro), 32'd1);

        // Reset mid-RUN: accept, one slice done, reset on the second.
        a = 8'h12; b = 8'h34; acc_mode = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready",  32'(in_ready),  32'd1);
        check("abort sum",       32'(sum),       32'd0);
        // acc must be 0 after the abort: 0 + 0x05.
        do_op(8'hEE, 8'h05, 1'b1, 1'b0, 0, rs, rc, ro);
        check("acc after abort", 32'(rs), 32'h05);

`ifdef ADDER_SUB_EN
        do_op(8'h10, 8'h20, 1'b0, 1'b1, 0, rs, rc, ro);
        check("sub1 sum", 32'(rs), 32'hF0);
        check("sub1 cout", 32'(rc), 32'd0);
        check("sub1 ovf", 32'(ro), 32'd0);
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 0, rs, rc, ro);
        check("sub2 sum", 32'(rs), 32'h7F);
        check("sub2 cout", 32'(rc), 32'd1);
        check("sub2 ovf", 32'(ro), 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
